ad7276_multi_if: RTL and testbench
==================================

AD7276_MULTI_IF -- requirements
Module: ad7276_multi_if

Interface
REQ-001 Parameter NUM_CH, default 2: number of ADCs sharing sclk_o/cs_o, range 1..8.
REQ-002 Parameter FRAME_BITS, default 16: SCLK periods per conversion frame.
REQ-003 Parameter DATA_BITS, default 12: result width per channel.
REQ-004 Parameter LEAD_BITS, default 2: leading frame bits discarded before the result.
REQ-005 Parameter SCLK_DIV, default 2: SCLK half-period in fpga_clk_i cycles, minimum 1.
REQ-006 Parameter CS_SETUP_CNT, default 2: fpga_clk_i cycles from cs_o falling to the first SCLK falling edge, minimum 1.
REQ-007 Parameter CYCLE_CNT, default 100: conversion period in fpga_clk_i cycles; must be at least CS_SETUP_CNT + 2*SCLK_DIV*FRAME_BITS + 2.
REQ-008 Parameter CONTINUOUS, default 1: 1 = free-running conversions; 0 = one conversion per trig_i pulse.
REQ-009 fpga_clk_i  in  1  sole clock; every flop is clocked on its rising edge.
REQ-010 reset_n_i  in  1  synchronous reset, active low.
REQ-011 en_i  in  NUM_CH  per-channel enable.
REQ-012 trig_i  in  1  single-shot trigger; ignored when CONTINUOUS=1.
REQ-013 data_i  in  NUM_CH  serial data from each ADC.
REQ-014 sclk_o  out  1  shared ADC serial clock; idles high.
REQ-015 cs_o  out  1  shared ADC chip select, active low.
REQ-016 data_o  out  NUM_CH*DATA_BITS  results; channel k occupies bits [k*DATA_BITS +: DATA_BITS].
REQ-017 data_rdy_o  out  1  one-cycle pulse when data_o updates.
REQ-018 busy_o  out  1  high whenever the FSM is outside IDLE.

Function
REQ-019 States SHALL be IDLE, SETUP, SHIFT and DONE, and sclk_o, cs_o, data_o, data_rdy_o and busy_o SHALL all be registered.
REQ-020 The period timer SHALL load CYCLE_CNT-1 on each IDLE->SETUP transition, decrement once per cycle, and hold at 0.
REQ-021 IDLE->SETUP SHALL occur when en_i != 0 and the timer is 0, and either CONTINUOUS=1 or trig_pend=1.
REQ-022 trig_pend SHALL set on trig_i=1 in any state and clear on IDLE->SETUP; a trig_i arriving in the same cycle as the clear SHALL leave trig_pend set.
REQ-023 en_i SHALL be latched into en_lat on IDLE->SETUP; changes to en_i during a conversion SHALL take effect at the next conversion only.
REQ-024 SETUP SHALL hold cs_o=0 and sclk_o=1 for CS_SETUP_CNT cycles, then go to SHIFT.
REQ-025 SHIFT SHALL produce FRAME_BITS SCLK periods, each SCLK_DIV cycles low followed by SCLK_DIV cycles high, so the first low half starts in the first SHIFT cycle.
REQ-026 On each cycle in which sclk_o goes from 0 to 1, every channel SHALL shift data_i[k] into its shift register, MSB first.
REQ-027 After the last high half, the FSM SHALL enter DONE, which lasts one cycle.
REQ-028 In DONE, cs_o SHALL go to 1, data_rdy_o SHALL be 1, and the FSM SHALL then return to IDLE.
REQ-029 In DONE, each channel with en_lat[k]=1 SHALL load frame bits [FRAME_BITS-1-LEAD_BITS -: DATA_BITS] into its slice of data_o.
REQ-030 In DONE, each channel with en_lat[k]=0 SHALL set its slice of data_o to 0.
REQ-031 data_o SHALL hold its value between DONE cycles.
REQ-032 Consecutive cs_o falling edges SHALL be exactly CYCLE_CNT cycles apart while the start condition holds continuously.
REQ-033 If en_i becomes 0 during a conversion, the conversion SHALL complete normally, and no new conversion SHALL start afterwards.

Reset
REQ-034 While reset_n_i=0 at a clock edge, the FSM SHALL enter IDLE, timer=0, trig_pend=0, en_lat=0, sclk_o=1, cs_o=1, data_o=0, data_rdy_o=0 and busy_o=0.
REQ-035 A reset asserted mid-conversion SHALL abort the frame without a data_rdy_o pulse; cs_o SHALL be 1 on the cycle after the reset edge.

Verification
REQ-036 Defaults, en_i=2'b11, ADC models drive frames 16'h2AF0 and 16'h048C -> data_o=24'h123ABC, one data_rdy_o pulse per frame, 16 SCLK periods of 4 cycles each.
REQ-037 Defaults, en_i held at 2'b11 -> cs_o falling edges exactly 100 cycles apart over 5 frames; cs_o-low-to-first-SCLK-fall = 2 cycles.
REQ-038 en_i=2'b01 -> data_o[23:12]=0 and data_o[11:0]=12'hABC; en_i toggled mid-SHIFT -> current frame unchanged, next frame reflects the new enable.
REQ-039 CONTINUOUS=0: no trig_i -> cs_o stays 1 for 500 cycles; one trig_i pulse -> exactly one frame; trig_i during SHIFT -> exactly one further frame once the timer reaches 0.
REQ-040 reset_n_i=0 at SCLK period 8 -> cs_o=1 on the next cycle, data_o=0, no data_rdy_o; normal frames resume after release.
REQ-041 NUM_CH=4, SCLK_DIV=1, CYCLE_CNT=40 -> 4 correct 12-bit results per frame, sclk_o period 2 cycles.

Source files
------------

// File: rtl/ad7276_multi_if_if.sv
// Bundle of the ADC-facing serial pins and the host-facing result/control signals.
// Latency: none; pure wiring between the controller and its environment.
// Backpressure: none; results are strobed and held, there is no ready path.
interface ad7276_multi_if_if #(
  parameter int NUM_CH    = 2,
  parameter int DATA_BITS = 12
);

  logic [NUM_CH-1:0]           en_i;
  logic                        trig_i;
  logic [NUM_CH-1:0]           data_i;
  logic                        sclk_o;
  logic                        cs_o;
  logic [NUM_CH*DATA_BITS-1:0] data_o;
  logic                        data_rdy_o;
  logic                        busy_o;

  // controller side
  modport master (
    input  en_i, trig_i, data_i,
    output sclk_o, cs_o, data_o, data_rdy_o, busy_o
  );

  // environment side (host logic plus the ADCs)
  modport slave (
    output en_i, trig_i, data_i,
    input  sclk_o, cs_o, data_o, data_rdy_o, busy_o
  );

endinterface

// File: rtl/ad7276_multi_if.sv
// Drives one shared SCLK/CS to NUM_CH AD7276-class ADCs and captures a result per channel per frame.
// Latency: data_o/data_rdy_o update one cycle after the last SCLK high half of the frame.
// Backpressure: none; data_rdy_o is a one-cycle strobe and data_o holds until the next frame.
module ad7276_multi_if #(
  parameter int NUM_CH       = 2,
  parameter int FRAME_BITS   = 16,
  parameter int DATA_BITS    = 12,
  parameter int LEAD_BITS    = 2,
  parameter int SCLK_DIV     = 2,
  parameter int CS_SETUP_CNT = 2,
  parameter int CYCLE_CNT    = 100,
  parameter int CONTINUOUS   = 1
) (
  input logic               fpga_clk_i,
  input logic               reset_n_i,
  ad7276_multi_if_if.master adc
);

  // Counter widths sized to hold their terminal values.
  localparam int TMR_W = (CYCLE_CNT > 1)    ? $clog2(CYCLE_CNT)    : 1;
  localparam int SET_W = (CS_SETUP_CNT > 1) ? $clog2(CS_SETUP_CNT) : 1;
  localparam int DIV_W = (SCLK_DIV > 1)     ? $clog2(SCLK_DIV)     : 1;
  localparam int BIT_W = (FRAME_BITS > 1)   ? $clog2(FRAME_BITS)   : 1;

  localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(CYCLE_CNT - 1);
  localparam logic [SET_W-1:0] SET_LAST = SET_W'(CS_SETUP_CNT - 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCLK_DIV - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(FRAME_BITS - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t                      state, state_nxt;
  logic [TMR_W-1:0]            timer, timer_nxt;
  logic [SET_W-1:0]            setup_cnt, setup_cnt_nxt;
  logic [DIV_W-1:0]            half_cnt, half_cnt_nxt;
  logic [BIT_W-1:0]            bit_cnt, bit_cnt_nxt;
  logic                        trig_pend, trig_pend_nxt;
  logic [NUM_CH-1:0]           en_lat, en_lat_nxt;
  logic                        sclk_q, sclk_nxt;
  logic                        cs_q, cs_nxt;
  logic                        rdy_q, rdy_nxt;
  logic                        busy_q;
  logic [NUM_CH*DATA_BITS-1:0] data_q, data_nxt;
  logic                        start;
  logic                        sample;

  // One shift register per ADC, filled MSB first.
  logic [FRAME_BITS-1:0]       shreg [NUM_CH];

  // Next-state logic; outputs are computed one cycle early so the pins come straight from flops.
  always_comb begin
    start         = (state == IDLE) && (adc.en_i != '0) && (timer == '0) &&
                    ((CONTINUOUS != 0) || trig_pend);
    sample        = 1'b0;
    state_nxt     = state;
    timer_nxt     = (timer != '0) ? timer - TMR_W'(1) : timer;
    setup_cnt_nxt = setup_cnt;
    half_cnt_nxt  = half_cnt;
    bit_cnt_nxt   = bit_cnt;
    en_lat_nxt    = en_lat;
    sclk_nxt      = sclk_q;
    cs_nxt        = cs_q;
    rdy_nxt       = 1'b0;
    data_nxt      = data_q;

    case (state)
      IDLE: begin
        if (start) begin
          state_nxt     = SETUP;
          timer_nxt     = TMR_LOAD;
          setup_cnt_nxt = '0;
          en_lat_nxt    = adc.en_i;
          cs_nxt        = 1'b0;
          sclk_nxt      = 1'b1;
        end
      end

      SETUP: begin
        if (setup_cnt == SET_LAST) begin
          // first SHIFT cycle is already the first SCLK low half
          state_nxt    = SHIFT;
          half_cnt_nxt = '0;
          bit_cnt_nxt  = '0;
          sclk_nxt     = 1'b0;
        end else begin
          setup_cnt_nxt = setup_cnt + SET_W'(1);
        end
      end

      SHIFT: begin
        if (half_cnt == DIV_LAST) begin
          half_cnt_nxt = '0;
          if (!sclk_q) begin
            // rising SCLK: the ADC bit has been stable for a whole low half
            sclk_nxt = 1'b1;
            sample   = 1'b1;
          end else if (bit_cnt == BIT_LAST) begin
            // end of the last high half: SCLK stays high into DONE
            state_nxt = DONE;
            cs_nxt    = 1'b1;
            rdy_nxt   = 1'b1;
            for (int k = 0; k < NUM_CH; k++) begin
              data_nxt[k*DATA_BITS +: DATA_BITS] =
                en_lat[k] ? shreg[k][FRAME_BITS-1-LEAD_BITS -: DATA_BITS] : '0;
            end
          end else begin
            sclk_nxt    = 1'b0;
            bit_cnt_nxt = bit_cnt + BIT_W'(1);
          end
        end else begin
          half_cnt_nxt = half_cnt + DIV_W'(1);
        end
      end

      DONE: begin
        state_nxt = IDLE;
      end

      default: begin
        state_nxt = IDLE;
      end
    endcase

    // a trigger landing on the start cycle survives the clear
    trig_pend_nxt = adc.trig_i | (trig_pend & ~start);
  end

  // State, counters and registered outputs.
  always_ff @(posedge fpga_clk_i) begin
    if (!reset_n_i) begin
      state     <= IDLE;
      timer     <= '0;
      setup_cnt <= '0;
      half_cnt  <= '0;
      bit_cnt   <= '0;
      trig_pend <= 1'b0;
      en_lat    <= '0;
      sclk_q    <= 1'b1;
      cs_q      <= 1'b1;
      rdy_q     <= 1'b0;
      busy_q    <= 1'b0;
      data_q    <= '0;
    end else begin
      state     <= state_nxt;
      timer     <= timer_nxt;
      setup_cnt <= setup_cnt_nxt;
      half_cnt  <= half_cnt_nxt;
      bit_cnt   <= bit_cnt_nxt;
      trig_pend <= trig_pend_nxt;
      en_lat    <= en_lat_nxt;
      sclk_q    <= sclk_nxt;
      cs_q      <= cs_nxt;
      rdy_q     <= rdy_nxt;
      busy_q    <= (state_nxt != IDLE);
      data_q    <= data_nxt;
    end
  end

  // Capture every channel on each SCLK rising edge; disabled channels are masked at DONE.
  always_ff @(posedge fpga_clk_i) begin
    if (!reset_n_i) begin
      for (int k = 0; k < NUM_CH; k++) begin
        shreg[k] <= '0;
      end
    end else if (sample) begin
      for (int k = 0; k < NUM_CH; k++) begin
        shreg[k] <= {shreg[k][FRAME_BITS-2:0], adc.data_i[k]};
      end
    end
  end

  assign adc.sclk_o     = sclk_q;
  assign adc.cs_o       = cs_q;
  assign adc.data_o     = data_q;
  assign adc.data_rdy_o = rdy_q;
  assign adc.busy_o     = busy_q;

endmodule

// File: tb/tb_ad7276_multi_if.sv
// Bench for ad7276_multi_if: a free-running 2-channel instance and a triggered 4-channel fast instance.
// Latency: ADC models drive each bit before the SCLK rising edge that captures it.
// Backpressure: none; results are scored on every data_rdy_o strobe.
module tb_ad7276_multi_if;

  logic clk;
  logic a_rst_n;
  logic b_rst_n;
  int   cyc;
  int   n_chk;
  int   n_pass;

  ad7276_multi_if_if #(.NUM_CH(2), .DATA_BITS(12)) a_if ();
  ad7276_multi_if_if #(.NUM_CH(4), .DATA_BITS(12)) b_if ();

  ad7276_multi_if #(.NUM_CH(2)) dut_a (
    .fpga_clk_i (clk),
    .reset_n_i  (a_rst_n),
    .adc        (a_if)
  );

  ad7276_multi_if #(
    .NUM_CH(4), .SCLK_DIV(1), .CYCLE_CNT(40), .CONTINUOUS(0)
  ) dut_b (
    .fpga_clk_i (clk),
    .reset_n_i  (b_rst_n),
    .adc        (b_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  // Result of a 16-bit frame: drop 2 leading bits, keep the next 12.
  function automatic logic [11:0] ref_res(input logic [15:0] frame);
    logic [15:0] t;
    t = frame >> 2;
    return t[11:0];
  endfunction

  // ---------------- instance A model / scoreboard ----------------
  logic [15:0] a_frame [2];
  logic [23:0] a_q [$];
  logic [23:0] a_exp;
  logic [1:0]  a_din;
  logic        a_cs_prev = 1'b1, a_sclk_prev = 1'b1, a_rdy_prev = 1'b0;
  bit          a_in, a_fixed, a_chk_period;
  int          a_rise, a_fall, a_per_bad, a_nstarts, a_nframes;
  int          a_last_fall = -1, a_cs_fall_cyc, a_sclk_fall_cyc;

  always @(posedge clk) begin
    #1;
    if (!a_rst_n) begin
      a_q.delete();
      a_in = 1'b0;
    end else begin
      if (a_cs_prev && !a_if.cs_o) begin
        a_nstarts++;
        if (a_chk_period && a_last_fall >= 0) check_val("a_cs_period", cyc - a_last_fall, 100);
        a_last_fall   = cyc;
        a_cs_fall_cyc = cyc;
        a_exp = '0;
        for (int k = 0; k < 2; k++) begin
          a_frame[k] = a_fixed ? ((k == 0) ? 16'h2AF0 : 16'h048C) : 16'($urandom);
          if (a_if.en_i[k]) a_exp = a_exp | (24'(ref_res(a_frame[k])) << (12 * k));
        end
        a_q.push_back(a_exp);
        a_rise = 0; a_fall = 0; a_per_bad = 0; a_in = 1'b1;
      end
      if (a_in && a_sclk_prev && !a_if.sclk_o) begin
        a_fall++;
        if (a_fall == 1) check_val("a_cs_to_sclk", cyc - a_cs_fall_cyc, 2);
        else if (cyc - a_sclk_fall_cyc != 4) a_per_bad++;
        a_sclk_fall_cyc = cyc;
      end
      if (a_in && !a_sclk_prev && a_if.sclk_o) a_rise++;
      if (a_if.data_rdy_o) begin
        a_nframes++;
        check_val("a_rdy_pulse", a_rdy_prev, 0);
        check_val("a_cs_in_done", a_if.cs_o, 1);
        check_val("a_sclk_periods", a_rise, 16);
        check_val("a_sclk_period_len", a_per_bad, 0);
        check_val("a_rdy_expected", a_q.size() > 0, 1);
        if (a_q.size() > 0) check_val("a_data", a_if.data_o, a_q.pop_front());
        a_in = 1'b0;
      end
    end
    a_cs_prev = a_if.cs_o; a_sclk_prev = a_if.sclk_o; a_rdy_prev = a_if.data_rdy_o;
    for (int k = 0; k < 2; k++) a_din[k] = (a_in && a_rise < 16) ? a_frame[k][15 - a_rise] : 1'b0;
    a_if.data_i = a_din;
  end

  // ---------------- instance B model / scoreboard ----------------
  logic [15:0] b_frame [4];
  logic [47:0] b_q [$];
  logic [47:0] b_exp;
  logic [3:0]  b_din;
  logic        b_cs_prev = 1'b1, b_sclk_prev = 1'b1, b_rdy_prev = 1'b0;
  bit          b_in;
  int          b_rise, b_fall, b_per_bad, b_nstarts, b_nframes;
  int          b_last_fall = -1, b_gap, b_sclk_fall_cyc;

  always @(posedge clk) begin
    #1;
    if (!b_rst_n) begin
      b_q.delete();
      b_in = 1'b0;
    end else begin
      if (b_cs_prev && !b_if.cs_o) begin
        b_nstarts++;
        b_gap       = (b_last_fall >= 0) ? cyc - b_last_fall : 0;
        b_last_fall = cyc;
        b_exp = '0;
        for (int k = 0; k < 4; k++) begin
          b_frame[k] = 16'($urandom);
          if (b_if.en_i[k]) b_exp = b_exp | (48'(ref_res(b_frame[k])) << (12 * k));
        end
        b_q.push_back(b_exp);
        b_rise = 0; b_fall = 0; b_per_bad = 0; b_in = 1'b1;
      end
      if (b_in && b_sclk_prev && !b_if.sclk_o) begin
        b_fall++;
        if (b_fall == 1) check_val("b_cs_to_sclk", cyc - b_last_fall, 2);
        else if (cyc - b_sclk_fall_cyc != 2) b_per_bad++;
        b_sclk_fall_cyc = cyc;
      end
      if (b_in && !b_sclk_prev && b_if.sclk_o) b_rise++;
      if (b_if.data_rdy_o) begin
        b_nframes++;
        check_val("b_rdy_pulse", b_rdy_prev, 0);
        check_val("b_sclk_periods", b_rise, 16);
        check_val("b_sclk_period_len", b_per_bad, 0);
        check_val("b_rdy_expected", b_q.size() > 0, 1);
        if (b_q.size() > 0) check_val("b_data", b_if.data_o, b_q.pop_front());
        b_in = 1'b0;
      end
    end
    b_cs_prev = b_if.cs_o; b_sclk_prev = b_if.sclk_o; b_rdy_prev = b_if.data_rdy_o;
    for (int k = 0; k < 4; k++) b_din[k] = (b_in && b_rise < 16) ? b_frame[k][15 - b_rise] : 1'b0;
    b_if.data_i = b_din;
  end

  // ---------------- bounded waits ----------------
  task automatic a_wait_fall(input int n);
    for (int i = 0; i < 300 && !(a_in && a_fall == n); i++) @(negedge clk);
    check_val("a_wait_sclk_fall", a_in && a_fall == n, 1);
  endtask

  task automatic a_wait_frames(input int n);
    int target;
    target = a_nframes + n;
    for (int i = 0; i < n * 120 + 150 && a_nframes < target; i++) @(negedge clk);
    check_val("a_wait_frames", a_nframes >= target, 1);
  endtask

  task automatic b_wait_fall(input int n);
    for (int i = 0; i < 200 && !(b_in && b_fall == n); i++) @(negedge clk);
    check_val("b_wait_sclk_fall", b_in && b_fall == n, 1);
  endtask

  task automatic b_wait_frames(input int n);
    int target;
    target = b_nframes + n;
    for (int i = 0; i < n * 60 + 100 && b_nframes < target; i++) @(negedge clk);
    check_val("b_wait_frames", b_nframes >= target, 1);
  endtask

  task automatic b_pulse_trig;
    @(negedge clk) b_if.trig_i = 1'b1;
    @(negedge clk) b_if.trig_i = 1'b0;
  endtask

  // ---------------- instance A sequence ----------------
  task automatic run_a;
    int st0, fr0;
    a_rst_n = 1'b0; a_if.en_i = 2'b00; a_if.trig_i = 1'b0;
    repeat (3) @(negedge clk);
    check_val("a_rst_cs", a_if.cs_o, 1);
    check_val("a_rst_sclk", a_if.sclk_o, 1);
    check_val("a_rst_data", a_if.data_o, 0);
    check_val("a_rst_rdy", a_if.data_rdy_o, 0);
    check_val("a_rst_busy", a_if.busy_o, 0);
    a_rst_n = 1'b1;
    repeat (20) @(negedge clk);
    check_val("a_en0_idle_busy", a_if.busy_o, 0);

    // directed frames, periodic starts
    a_fixed = 1'b1; a_chk_period = 1'b1; a_if.en_i = 2'b11;
    a_wait_frames(5);
    check_val("a_data_fixed", a_if.data_o, 24'h123ABC);
    a_fixed = 1'b0;

    // single channel enabled
    a_if.en_i = 2'b01;
    a_wait_frames(2);
    check_val("a_ch1_zero", a_if.data_o[23:12], 0);

    // enable change mid-SHIFT applies to the next frame
    a_wait_fall(4);
    a_if.en_i = 2'b10;
    a_wait_frames(1);
    check_val("a_toggle_cur_hi", a_if.data_o[23:12], 0);
    a_wait_frames(1);
    check_val("a_toggle_next_lo", a_if.data_o[11:0], 0);

    // all enables dropped mid-frame: frame completes, nothing restarts
    a_chk_period = 1'b0;
    a_wait_fall(4);
    a_if.en_i = 2'b00;
    st0 = a_nstarts;
    a_wait_frames(1);
    repeat (300) @(negedge clk);
    check_val("a_en0_no_restart", a_nstarts - st0, 0);
    check_val("a_en0_busy", a_if.busy_o, 0);

    // reset during SCLK period 8
    a_if.en_i = 2'b11;
    a_wait_fall(8);
    fr0 = a_nframes;
    a_rst_n = 1'b0;
    @(posedge clk);
    #2;
    check_val("a_midrst_cs", a_if.cs_o, 1);
    check_val("a_midrst_data", a_if.data_o, 0);
    check_val("a_midrst_rdy", a_if.data_rdy_o, 0);
    check_val("a_midrst_busy", a_if.busy_o, 0);
    @(negedge clk) a_rst_n = 1'b1;
    check_val("a_midrst_no_frame", a_nframes - fr0, 0);
    a_wait_frames(2);

    a_if.en_i = 2'b00;
    for (int i = 0; i < 200 && a_if.busy_o; i++) @(negedge clk);
    check_val("a_final_idle", a_if.busy_o, 0);
    check_val("a_q_empty", a_q.size(), 0);
    check_val("a_starts_vs_rdy", a_nstarts - a_nframes, 1);
  endtask

  // ---------------- instance B sequence ----------------
  task automatic run_b;
    b_rst_n = 1'b0; b_if.en_i = 4'h0; b_if.trig_i = 1'b0;
    repeat (3) @(negedge clk);
    check_val("b_rst_cs", b_if.cs_o, 1);
    check_val("b_rst_data", b_if.data_o, 0);
    b_rst_n = 1'b1;
    b_if.en_i = 4'hF;
    repeat (500) @(negedge clk);
    check_val("b_notrig_starts", b_nstarts, 0);
    check_val("b_notrig_cs", b_if.cs_o, 1);

    b_pulse_trig();
    b_wait_frames(1);
    repeat (100) @(negedge clk);
    check_val("b_one_shot", b_nstarts, 1);

    // trigger during SHIFT queues exactly one more frame at the period boundary
    b_if.en_i = 4'b0101;
    b_pulse_trig();
    b_wait_fall(5);
    b_pulse_trig();
    b_wait_frames(2);
    repeat (100) @(negedge clk);
    check_val("b_retrig_starts", b_nstarts, 3);
    check_val("b_retrig_gap", b_gap, 40);

    // trigger while disabled is remembered until an enable appears
    b_if.en_i = 4'h0;
    b_pulse_trig();
    repeat (100) @(negedge clk);
    check_val("b_pend_no_en", b_nstarts, 3);
    b_if.en_i = 4'hF;
    b_wait_frames(1);
    check_val("b_pend_with_en", b_nstarts, 4);

    for (int n = 0; n < 3; n++) begin
      b_if.en_i = 4'($urandom_range(1, 15));
      b_pulse_trig();
      b_wait_frames(1);
    end
    repeat (100) @(negedge clk);
    check_val("b_total_starts", b_nstarts, 7);
    check_val("b_total_frames", b_nframes, 7);
    check_val("b_q_empty", b_q.size(), 0);
  endtask

  initial begin
    n_chk = 0; n_pass = 0; cyc = 0;
    a_rst_n = 1'b0; b_rst_n = 1'b0;
    a_if.en_i = '0; a_if.trig_i = 1'b0; a_if.data_i = '0;
    b_if.en_i = '0; b_if.trig_i = 1'b0; b_if.data_i = '0;
    fork
      run_a();
      run_b();
    join
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
